lock_ctrl: RTL

//  Password-lock sequencer for the keypad lock. Consumes decoded key events, runs the

---
 rtl/lock_pkg.sv | 58 +++++
 rtl/lock_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - keypad lock state, key and display character definitions
package lock_pkg;

  typedef enum logic [2:0] {
    LOCKED  = 3'd0,
    INPUT   = 3'd1,
    OPEN    = 3'd2,
    ERR     = 3'd3,
    LOCKOUT = 3'd4
  } lock_state_t;

  localparam logic [3:0] KEY_CONFIRM = 4'd10;
  localparam logic [3:0] KEY_BACK    = 4'd11;
  localparam logic [3:0] KEY_LOCK    = 4'd12;

  localparam logic [4:0] CH_O     = 5'h10;
  localparam logic [4:0] CH_P     = 5'h11;
  localparam logic [4:0] CH_E     = 5'h12;
  localparam logic [4:0] CH_N     = 5'h13;
  localparam logic [4:0] CH_L     = 5'h14;
  localparam logic [4:0] CH_C     = 5'h15;
  localparam logic [4:0] CH_K     = 5'h16;
  localparam logic [4:0] CH_D     = 5'h17;
  localparam logic [4:0] CH_R     = 5'h18;
  localparam logic [4:0] CH_BLANK = 5'h1F;

  // Six 5-bit character codes; element k is display digit k (k=0 leftmost).
  function automatic logic [5:0][4:0] text_for_state(
    input lock_state_t     st,
    input logic [3:0][3:0] entry,
    input logic [2:0]      len,
    input logic [2:0]      fail_cnt
  );
    logic [5:0][4:0] t;
    t = {6{CH_BLANK}};
    case (st)
      LOCKED: begin
        t[0] = CH_L; t[1] = CH_O; t[2] = CH_C;
        t[3] = CH_K; t[4] = CH_E; t[5] = CH_D;
      end
      INPUT: begin
        for (int i = 0; i < 4; i++) begin
          if (i < int'(len)) t[i] = {1'b0, entry[i]};
        end
      end
      OPEN: begin
        t[0] = CH_O; t[1] = CH_P; t[2] = CH_E; t[3] = CH_N;
      end
      ERR, LOCKOUT: begin
        t[0] = CH_E; t[1] = CH_R; t[2] = CH_R;
        t[5] = {2'b00, fail_cnt};
      end
      default: t = {6{CH_BLANK}};
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lock_ctrl.sv
// rtl/lock_ctrl.sv - keypad password lock sequencer driving the 6-digit display bus
module lock_ctrl
  import lock_pkg::*;
#(
  parameter int          SEGMENT_NUM = 6,
  parameter int          W_DATA      = 5,
  parameter logic [15:0] PASSWORD    = 16'h1234,
  parameter int          MAX_FAIL    = 3,
  parameter int          T_OPEN      = 250_000_000,
  parameter int          T_ERR       = 50_000_000,
  parameter int          T_LOCKOUT   = 500_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    key_num,
  input  logic                          key_vld,
  output logic [SEGMENT_NUM*W_DATA-1:0] din,
  output logic [SEGMENT_NUM-1:0]        din_vld,
  output logic                          unlock,
  output logic                          alarm
);

  localparam int T_MAX01 = (T_OPEN > T_ERR) ? T_OPEN : T_ERR;
  localparam int T_MAX   = (T_MAX01 > T_LOCKOUT) ? T_MAX01 : T_LOCKOUT;
  localparam int TW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  lock_state_t                   state_q, state_d;
  logic [3:0][3:0]               entry_q, entry_d;
  logic [2:0]                    len_q, len_d;
  logic [2:0]                    fail_q, fail_d;
  logic [TW-1:0]                 timer_q, timer_d;
  logic [SEGMENT_NUM*W_DATA-1:0] din_q, din_d;
  logic [SEGMENT_NUM-1:0]        din_vld_q, din_vld_d;
  logic                          unlock_q, unlock_d;
  logic                          alarm_q, alarm_d;

  logic key_digit;
  logic pw_match;

  assign key_digit = key_vld && (key_num <= 4'd9);
  assign pw_match  = (len_q == 3'd4) &&
                     ({entry_q[0], entry_q[1], entry_q[2], entry_q[3]} == PASSWORD);

  // Next-state, entry buffer, failure count, shared timer and registered display outputs.
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    len_d     = len_q;
    fail_d    = fail_q;
    timer_d   = timer_q;
    din_d     = text_for_state(state_q, entry_q, len_q, fail_q);
    din_vld_d = '1;
    unlock_d  = (state_q == OPEN);
    alarm_d   = (state_q == LOCKOUT);

    case (state_q)
      LOCKED: begin
        if (key_digit) begin
          state_d    = INPUT;
          entry_d[0] = key_num;
          len_d      = 3'd1;
        end
      end
      INPUT: begin
        if (key_digit) begin
          if (len_q < 3'd4) begin
            entry_d[len_q[1:0]] = key_num;
            len_d               = len_q + 3'd1;
          end
        end else if (key_vld && key_num == KEY_BACK) begin
          if (len_q > 3'd1) len_d = len_q - 3'd1;
          else state_d = LOCKED;
        end else if (key_vld && key_num == KEY_LOCK) begin
          state_d = LOCKED;
        end else if (key_vld && key_num == KEY_CONFIRM) begin
          if (pw_match) begin
            state_d = OPEN;
            fail_d  = 3'd0;
          end else begin
            state_d = ERR;
            if (fail_q < 3'(MAX_FAIL)) fail_d = fail_q + 3'd1;
          end
        end
      end
      OPEN: begin
        if (timer_q == TW'(T_OPEN - 1) || (key_vld && key_num == KEY_LOCK)) state_d = LOCKED;
      end
      ERR: begin
        if (timer_q == TW'(T_ERR - 1)) state_d = (fail_q == 3'(MAX_FAIL)) ? LOCKOUT : LOCKED;
      end
      LOCKOUT: begin
        if (timer_q == TW'(T_LOCKOUT - 1)) begin
          state_d = LOCKED;
          fail_d  = 3'd0;
        end
      end
      default: state_d = LOCKED;
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
      if (state_d == LOCKED || state_d == OPEN || state_d == ERR) begin
        entry_d = '0;
        len_d   = 3'd0;
      end
    end else if (state_q == OPEN || state_q == ERR || state_q == LOCKOUT) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = '0;
    end
  end

  // State and output registers; reset clears everything including the failure count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOCKED;
      entry_q   <= '0;
      len_q     <= 3'd0;
      fail_q    <= 3'd0;
      timer_q   <= '0;
      din_q     <= {SEGMENT_NUM{CH_BLANK}};
      din_vld_q <= '0;
      unlock_q  <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      len_q     <= len_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
      din_q     <= din_d;
      din_vld_q <= din_vld_d;
      unlock_q  <= unlock_d;
      alarm_q   <= alarm_d;
    end
  end

  assign din     = din_q;
  assign din_vld = din_vld_q;
  assign unlock  = unlock_q;
  assign alarm   = alarm_q;

endmodule
